// File: rtl/wallace_rr_scheduler_if.sv
// Bundle between the round-robin scheduler, its requesters and the shared Wallace tree.
// The master modport is the scheduler side; the slave modport is the surrounding environment.
interface wallace_rr_scheduler_if #(
  parameter int N    = 1024,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*N*16-1:0] req_data;
  logic                 tree_in_valid;
  logic                 tree_in_ready;
  logic [N*16-1:0]      tree_in_flat;
  logic                 tree_out_valid;
  logic [31:0]          tree_out;
  logic                 resp_valid;
  logic [IDW-1:0]       resp_id;
  logic [31:0]          resp_data;
  logic                 busy;
  logic                 err_orphan;

  modport master (
    input  req_valid, req_data, tree_in_ready, tree_out_valid, tree_out,
    output req_ready, tree_in_valid, tree_in_flat, resp_valid, resp_id, resp_data,
           busy, err_orphan
  );

  modport slave (
    output req_valid, req_data, tree_in_ready, tree_out_valid, tree_out,
    input  req_ready, tree_in_valid, tree_in_flat, resp_valid, resp_id, resp_data,
           busy, err_orphan
  );
endinterface

// File: rtl/wallace_rr_scheduler.sv
// Round-robin arbiter sharing one fixed-latency Wallace tree between NREQ requesters.
// Issued requester IDs ride a 4-deep tag FIFO so each returning sum is routed to its owner.
module wallace_rr_scheduler #(
  parameter int N            = 1024,
  parameter int NREQ         = 4,
  parameter int IDW          = 2,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  wallace_rr_scheduler_if.master bus
);
  localparam int             DEPTH   = 4;
  localparam logic [IDW-1:0] PTR_RST = IDW'(NREQ - 1);
  localparam logic [2:0]     CAP     = 3'(MAX_INFLIGHT);

  logic [IDW-1:0]  ptr_r;
  logic            issued_prev_r;
  logic [IDW-1:0]  tag_mem_r [DEPTH];
  logic [1:0]      wr_ptr_r;
  logic [1:0]      rd_ptr_r;
  logic [2:0]      count_r;
  logic            resp_valid_r;
  logic [IDW-1:0]  resp_id_r;
  logic [31:0]     resp_data_r;
  logic            busy_r;
  logic            err_orphan_r;

  logic            found_s;
  logic [IDW-1:0]  winner_s;
  logic [IDW-1:0]  cand_s;
  logic            issue_s;
  logic            push_s;
  logic            pop_s;
  logic            orphan_s;
  logic [2:0]      count_next_s;
  logic [IDW-1:0]  head_s;
  logic [NREQ-1:0] req_ready_s;
  logic [N*16-1:0] flat_s;

  // Rotating search: first pending requester after the last winner, wrapping modulo NREQ
  always_comb begin
    found_s  = 1'b0;
    cand_s   = '0;
    winner_s = IDW'((int'(ptr_r) + 1) % NREQ);
    for (int k = 1; k <= NREQ; k++) begin
      cand_s   = IDW'((int'(ptr_r) + k) % NREQ);
      winner_s = (!found_s && bus.req_valid[cand_s]) ? cand_s : winner_s;
      found_s  = found_s | bus.req_valid[cand_s];
    end
  end

  // Issue qualification; gating with rst keeps the handshake quiet during reset
  always_comb begin
    issue_s  = rst & found_s & bus.tree_in_ready & ~issued_prev_r & (count_r < CAP);
    push_s   = issue_s;
    pop_s    = bus.tree_out_valid & (count_r != 3'd0);
    orphan_s = bus.tree_out_valid & (count_r == 3'd0);
    head_s   = tag_mem_r[rd_ptr_r];
  end

  // Grant decode and vector mux; the mux follows the search default when nothing issues
  always_comb begin
    req_ready_s = '0;
    flat_s      = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready_s[i] = issue_s && (winner_s == IDW'(i));
      flat_s         = (winner_s == IDW'(i)) ? bus.req_data[i*N*16 +: N*16] : flat_s;
    end
  end

  // Occupancy after this cycle's push/pop
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 3'd1;
      2'b01:   count_next_s = count_r - 3'd1;
      default: count_next_s = count_r;
    endcase
  end

  // Tag FIFO holding requester IDs in issue order
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= winner_s;
        wr_ptr_r            <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      count_r <= count_next_s;
    end
  end

  // Arbitration pointer and one-issue-per-two-cycles spacing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r         <= PTR_RST;
      issued_prev_r <= 1'b0;
    end else begin
      ptr_r         <= issue_s ? winner_s : ptr_r;
      issued_prev_r <= issue_s;
    end
  end

  // Response routing, occupancy flag and sticky orphan error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid_r <= 1'b0;
      resp_id_r    <= '0;
      resp_data_r  <= 32'd0;
      busy_r       <= 1'b0;
      err_orphan_r <= 1'b0;
    end else begin
      resp_valid_r <= bus.tree_out_valid;
      if (bus.tree_out_valid) begin
        resp_id_r   <= pop_s ? head_s : '0;
        resp_data_r <= bus.tree_out;
      end
      busy_r <= (count_next_s != 3'd0);
      if (orphan_s) begin
        err_orphan_r <= 1'b1;
      end
    end
  end

  assign bus.req_ready     = req_ready_s;
  assign bus.tree_in_valid = issue_s;
  assign bus.tree_in_flat  = flat_s;
  assign bus.resp_valid    = resp_valid_r;
  assign bus.resp_id       = resp_id_r;
  assign bus.resp_data     = resp_data_r;
  assign bus.busy          = busy_r;
  assign bus.err_orphan    = err_orphan_r;
endmodule

// File: tb/tb_wallace_rr_scheduler.sv
// Directed bench for wallace_rr_scheduler with a behavioural fixed-latency tree model.
module tb_wallace_rr_scheduler;
  localparam int N    = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wallace_rr_scheduler_if #(.N(N), .NREQ(NREQ), .IDW(IDW)) bus ();

  wallace_rr_scheduler #(.N(N), .NREQ(NREQ), .IDW(IDW), .MAX_INFLIGHT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int lat       = 5;
  logic        inj_valid = 1'b0;
  logic [31:0] inj_data  = 32'd0;

  typedef struct {
    int          due;
    logic [31:0] sum;
  } tx_t;
  tx_t tq[$];

  typedef struct {
    logic [3:0]  rv;
    logic [3:0]  ready;
    logic        rvld;
    logic [1:0]  rid;
    logic [31:0] rdata;
    logic        busy;
  } vec_t;
  vec_t tbl [18];

  function automatic logic [31:0] vsum(input logic [N*16-1:0] v);
    logic [31:0] s = 32'd0;
    for (int j = 0; j < N; j++) s = s + 32'(v[j*16 +: 16]);
    return s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Tree model: results appear lat cycles after the accepting edge; optional orphan injection
  always @(negedge clk) begin
    if (!rst) begin
      tq.delete();
      bus.tree_out_valid <= 1'b0;
      bus.tree_out       <= 32'd0;
    end else begin
      if (inj_valid) begin
        bus.tree_out_valid <= 1'b1;
        bus.tree_out       <= inj_data;
      end else if (tq.size() > 0 && tq[0].due == cyc) begin
        bus.tree_out_valid <= 1'b1;
        bus.tree_out       <= tq[0].sum;
        tq.delete(0);
      end else begin
        bus.tree_out_valid <= 1'b0;
      end
      if (bus.tree_in_valid && bus.tree_in_ready)
        tq.push_back('{cyc + lat, vsum(bus.tree_in_flat)});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    bus.req_data[i*N*16 +: N*16] = {d, c, b, a};
  endtask

  task automatic drain(input string name);
    int i = 0;
    @(negedge clk);
    while (bus.busy && i < 60) begin
      @(negedge clk);
      i++;
    end
    chk(name, 32'(bus.busy), 32'd0);
    nxt();
  endtask

  function automatic logic [3:0] cap_grant(input int c);
    case (c)
      0:       return 4'b0010;
      2:       return 4'b0100;
      4:       return 4'b1000;
      21:      return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] fair_exp [11];
    fair_exp = '{4'b1000, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000,
                 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    // rv, ready, resp_valid, resp_id, resp_data, busy
    tbl[0]  = '{4'b1111, 4'b0001, 1'b0, 2'd0, 32'd0,  1'b0};
    tbl[1]  = '{4'b1111, 4'b0000, 1'b0, 2'd0, 32'd0,  1'b1};
    tbl[2]  = '{4'b1111, 4'b0010, 1'b0, 2'd0, 32'd0,  1'b1};
    tbl[3]  = '{4'b1111, 4'b0000, 1'b0, 2'd0, 32'd0,  1'b1};
    tbl[4]  = '{4'b1111, 4'b0100, 1'b0, 2'd0, 32'd0,  1'b1};
    tbl[5]  = '{4'b1111, 4'b0000, 1'b0, 2'd0, 32'd0,  1'b1};
    tbl[6]  = '{4'b1111, 4'b1000, 1'b1, 2'd0, 32'd10, 1'b1};
    tbl[7]  = '{4'b1111, 4'b0000, 1'b0, 2'd0, 32'd10, 1'b1};
    tbl[8]  = '{4'b1111, 4'b0001, 1'b1, 2'd1, 32'd20, 1'b1};
    tbl[9]  = '{4'b1111, 4'b0000, 1'b0, 2'd1, 32'd20, 1'b1};
    tbl[10] = '{4'b1111, 4'b0010, 1'b1, 2'd2, 32'd30, 1'b1};
    tbl[11] = '{4'b0000, 4'b0000, 1'b0, 2'd2, 32'd30, 1'b1};
    tbl[12] = '{4'b0000, 4'b0000, 1'b1, 2'd3, 32'd40, 1'b1};
    tbl[13] = '{4'b0000, 4'b0000, 1'b0, 2'd3, 32'd40, 1'b1};
    tbl[14] = '{4'b0000, 4'b0000, 1'b1, 2'd0, 32'd10, 1'b1};
    tbl[15] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 32'd10, 1'b1};
    tbl[16] = '{4'b0000, 4'b0000, 1'b1, 2'd1, 32'd20, 1'b0};
    tbl[17] = '{4'b0000, 4'b0000, 1'b0, 2'd1, 32'd20, 1'b0};

    bus.req_valid     = 4'b1111;
    bus.tree_in_ready = 1'b1;
    bus.req_data      = '0;
    set_vec(0, 16'd1, 16'd2, 16'd3,  16'd4);
    set_vec(1, 16'd2, 16'd4, 16'd6,  16'd8);
    set_vec(2, 16'd3, 16'd6, 16'd9,  16'd12);
    set_vec(3, 16'd4, 16'd8, 16'd12, 16'd16);

    // Reset state with requests pending
    nxt();
    nxt();
    @(negedge clk);
    chk("rst req_ready",     32'(bus.req_ready),     32'd0);
    chk("rst tree_in_valid", 32'(bus.tree_in_valid), 32'd0);
    chk("rst resp_valid",    32'(bus.resp_valid),    32'd0);
    chk("rst resp_id",       32'(bus.resp_id),       32'd0);
    chk("rst resp_data",     bus.resp_data,          32'd0);
    chk("rst busy",          32'(bus.busy),          32'd0);
    chk("rst err_orphan",    32'(bus.err_orphan),    32'd0);
    nxt();
    rst = 1'b1;

    // All four requesters, cycle-by-cycle table
    for (int k = 0; k < 18; k++) begin
      bus.req_valid = tbl[k].rv;
      @(negedge clk);
      chk($sformatf("tbl%0d req_ready", k),  32'(bus.req_ready),  32'(tbl[k].ready));
      chk($sformatf("tbl%0d resp_valid", k), 32'(bus.resp_valid), 32'(tbl[k].rvld));
      chk($sformatf("tbl%0d resp_id", k),    32'(bus.resp_id),    32'(tbl[k].rid));
      chk($sformatf("tbl%0d resp_data", k),  bus.resp_data,       tbl[k].rdata);
      chk($sformatf("tbl%0d busy", k),       32'(bus.busy),       32'(tbl[k].busy));
      nxt();
    end

    // Single request from requester 2, sum 10, response six cycles after the grant
    set_vec(2, 16'd1, 16'd2, 16'd3, 16'd4);
    nxt();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("single grant", 32'(bus.req_ready), 32'b0100);
    chk("single busy0", 32'(bus.busy),      32'd0);
    nxt();
    bus.req_valid = 4'b0000;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk($sformatf("single resp_valid+%0d", i), 32'(bus.resp_valid), 32'(i == 6));
      chk($sformatf("single busy+%0d", i),       32'(bus.busy),       32'(i <= 5));
      if (i == 6) begin
        chk("single resp_id",   32'(bus.resp_id), 32'd2);
        chk("single resp_data", bus.resp_data,    32'd10);
      end
      nxt();
    end

    // Fairness: 1 and 3 alternate, then a new requester 0 beats requester 1
    for (int c = 0; c < 11; c++) begin
      bus.req_valid = (c >= 9) ? 4'b1011 : 4'b1010;
      @(negedge clk);
      chk($sformatf("fair grant c%0d", c), 32'(bus.req_ready), 32'(fair_exp[c]));
      nxt();
    end
    bus.req_valid = 4'b0000;
    drain("fair drain busy");

    // In-flight cap with a slow tree
    lat = 20;
    for (int c = 0; c < 22; c++) begin
      bus.req_valid = 4'b1111;
      @(negedge clk);
      chk($sformatf("cap grant c%0d", c), 32'(bus.req_ready), 32'(cap_grant(c)));
      if (c >= 5 && c <= 20) chk($sformatf("cap busy c%0d", c), 32'(bus.busy), 32'd1);
      nxt();
    end
    bus.req_valid = 4'b0000;
    lat = 5;
    drain("cap drain busy");

    // Orphan result while idle
    inj_valid = 1'b1;
    inj_data  = 32'h55;
    @(negedge clk);
    chk("orphan pre err", 32'(bus.err_orphan), 32'd0);
    nxt();
    inj_valid = 1'b0;
    @(negedge clk);
    chk("orphan err",        32'(bus.err_orphan), 32'd1);
    chk("orphan resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("orphan resp_id",    32'(bus.resp_id),    32'd0);
    chk("orphan resp_data",  bus.resp_data,       32'h55);
    chk("orphan busy",       32'(bus.busy),       32'd0);
    nxt();
    nxt();
    nxt();
    @(negedge clk);
    chk("orphan err sticky",  32'(bus.err_orphan), 32'd1);
    chk("orphan pulse ended", 32'(bus.resp_valid), 32'd0);
    nxt();

    // Reset with two transactions in flight
    bus.req_valid = 4'b1111;
    nxt();
    nxt();
    @(negedge clk);
    chk("midrst busy before", 32'(bus.busy), 32'd1);
    nxt();
    rst           = 1'b0;
    bus.req_valid = 4'b0000;
    @(negedge clk);
    chk("midrst req_ready",     32'(bus.req_ready),     32'd0);
    chk("midrst tree_in_valid", 32'(bus.tree_in_valid), 32'd0);
    chk("midrst resp_valid",    32'(bus.resp_valid),    32'd0);
    chk("midrst resp_id",       32'(bus.resp_id),       32'd0);
    chk("midrst resp_data",     bus.resp_data,          32'd0);
    chk("midrst busy",          32'(bus.busy),          32'd0);
    chk("midrst err_orphan",    32'(bus.err_orphan),    32'd0);
    nxt();
    nxt();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("postrst no resp %0d", i), 32'(bus.resp_valid), 32'd0);
      nxt();
    end
    bus.tree_in_ready = 1'b0;
    bus.req_valid     = 4'b1111;
    @(negedge clk);
    chk("tree not ready grant", 32'(bus.req_ready),     32'd0);
    chk("tree not ready issue", 32'(bus.tree_in_valid), 32'd0);
    nxt();
    bus.tree_in_ready = 1'b1;
    @(negedge clk);
    chk("postrst first grant", 32'(bus.req_ready), 32'b0001);
    nxt();
    bus.req_valid = 4'b0000;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 6) begin
        chk("postrst resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("postrst resp_id",    32'(bus.resp_id),    32'd0);
        chk("postrst resp_data",  bus.resp_data,       32'd10);
      end
      nxt();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/wallace_rr_scheduler.md
Name: wallace_rr_scheduler

Overview:
Round-robin scheduler that shares one WallaceTree reduction unit between NREQ requesters. It selects one pending vector, drives it into the tree, and tags the transaction in an in-flight FIFO. Because the tree has a fixed latency, each returned sum is routed back with its requester ID. It sits between the mixer-layer dot-product clients and the single shared tree instance.

Parameters:
N, 1024, elements per vector (16-bit unsigned each); must match the attached tree
NREQ, 4, number of requesters (2..16)
IDW, 2, requester ID width, equal to clog2(NREQ)
MAX_INFLIGHT, 3, maximum issued-but-unreturned transactions; tag FIFO depth is 4

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester request pending
req_ready  out  NREQ  one-hot accept pulse; transfer occurs when req_valid[i] and req_ready[i] are both high
req_data  in  NREQ*N*16  requester i vector at [i*N*16 +: N*16]
tree_in_valid  out  1  issue strobe to tree
tree_in_ready  in  1  tree ready
tree_in_flat  out  N*16  selected vector
tree_out_valid  in  1  tree result strobe
tree_out  in  32  tree result
resp_valid  out  1  one-cycle result pulse
resp_id  out  IDW  requester owning the result
resp_data  out  32  reduction sum
busy  out  1  in-flight count nonzero
err_orphan  out  1  sticky: tree result arrived with empty tag FIFO

Behaviour:
- Reset (rst low, async): FIFO emptied, count 0, RR pointer = NREQ-1 (requester 0 wins first), issued_prev=0, err_orphan=0. Registered outputs are 0: resp_valid, resp_id, resp_data, busy. Combinational outputs req_ready and tree_in_valid are 0 while rst is low. At top level the tree's rst is driven by ~rst; in-flight results are discarded and no stale response is emitted after reset release.
- Issue condition (combinational): any req_valid, and tree_in_ready=1, and issued_prev=0, and count < MAX_INFLIGHT.
- The issued_prev rule enforces at most one issue every 2 cycles. This matches the tree, whose in_ready drops the cycle after an accept.
- Winner: first asserted req_valid searching from pointer+1 upward, wrapping modulo NREQ.
- On issue, all in the same cycle:
  - tree_in_valid=1, req_ready[winner]=1, tree_in_flat = req_data slice of the winner (combinational mux).
  - On the clock edge: pointer<=winner, winner ID pushed to FIFO, issued_prev<=1.
- With no issue: tree_in_valid=0, req_ready=0, tree_in_flat holds the slice of the pointer+1 requester (don't-care for checking), issued_prev<=0.
- Requesters hold req_valid and req_data until accepted. Dropping req_valid before accept is legal; that requester simply loses the slot.
- On tree_out_valid:
  - FIFO head popped; on the next edge resp_valid<=1, resp_id<=head, resp_data<=tree_out.
  - Otherwise resp_valid<=0; resp_id and resp_data hold their values.
  - There is no response backpressure; clients must accept resp_valid.
- FIFO:
  - Simultaneous push and pop: count unchanged, ordering preserved.
  - Pointers wrap modulo 4.
  - Push when count=MAX_INFLIGHT is impossible by the issue condition.
- Orphan: tree_out_valid with count=0 sets err_orphan (held until reset). No pop occurs; resp_valid still pulses with resp_id=0 and the data.
- Latency: request accept edge at cycle t, tree out_valid at t+5, resp_valid at t+6. With one issue per 2 cycles, at most 3 transactions are in flight.
- busy = (count != 0), registered.
- Responses return in issue order, since the tree has fixed latency.
- Width: sums are unsigned 32-bit. They cannot overflow for N ≤ 65537.

Test Plan:
- Single request: N=4, req 2 data {1,2,3,4} → req_ready[2] one pulse; resp_valid 6 cycles later with resp_id=2, resp_data=10; busy high 0→1→0.
- All 4 requesters valid continuously, distinct data (sums 10, 20, 30, 40 for IDs 0–3) → grants 0,1,2,3,0 at cycles t, t+2, t+4, t+6, t+8; responses in the same order with matching sums; never 2 issues in consecutive cycles.
- Fairness: req 1 and req 3 always valid → grants alternate 1,3,1,3; after the last grant to 3, a new req 0 beats req 1.
- Inflight cap: tree model delays out_valid to 20 cycles → exactly 3 issues, then req_ready stays 0 until the first result returns, then issue resumes.
- Orphan: inject tree_out_valid with 0x55 while idle → err_orphan=1 and stays set; resp_valid pulse with resp_data=0x55.
- Reset mid-flight: assert rst low with 2 in flight → all outputs 0 immediately; after release, no resp_valid until a new request; first grant goes to requester 0.
